psg_multi: RTL

Parametrised successor to the single SN76489 sound block. It contains NUM_CHIPS independent SN76489-compatible cores, each with 3 tone channels and 1 noise channel. Each core has its own active-low chip select; all cores share the captured host data bus and the host write strobe. A saturating mixer sums every channel into one unsigned sample, with a one-cycle valid pulse at each prescaled sound tick. It sits beside memory_interface in chip and replaces the single sound instance.

---
 rtl/psg_pkg.sv | 51 +++++
 rtl/psg_core.sv | 101 ++++++++++
 rtl/psg_multi.sv | 89 ++++++++
 3 files changed

// File: rtl/psg_pkg.sv
// Shared constants for the SN76489-compatible sound cores: volume curve,
// LFSR seed, register indices and noise reload rates.
package psg_pkg;

  localparam logic [2:0] TONE0_F    = 3'd0;
  localparam logic [2:0] TONE0_ATT  = 3'd1;
  localparam logic [2:0] TONE1_F    = 3'd2;
  localparam logic [2:0] TONE1_ATT  = 3'd3;
  localparam logic [2:0] TONE2_F    = 3'd4;
  localparam logic [2:0] TONE2_ATT  = 3'd5;
  localparam logic [2:0] NOISE_CTRL = 3'd6;
  localparam logic [2:0] NOISE_ATT  = 3'd7;

  localparam logic [14:0] LFSR_SEED = 15'h4000;

  localparam int NOISE_RELOAD_0 = 16;
  localparam int NOISE_RELOAD_1 = 32;
  localparam int NOISE_RELOAD_2 = 64;

  // Counter reload value (period - 1) for the three fixed noise rates.
  function automatic logic [5:0] noise_reload(input logic [1:0] rate);
    case (rate)
      2'd0:    return 6'(NOISE_RELOAD_0 - 1);
      2'd1:    return 6'(NOISE_RELOAD_1 - 1);
      default: return 6'(NOISE_RELOAD_2 - 1);
    endcase
  endfunction

  // Roughly 2 dB per attenuation step, 4'hF is silence.
  function automatic logic [9:0] vol_lookup(input logic [3:0] att);
    case (att)
      4'd0:    return 10'd1023;
      4'd1:    return 10'd813;
      4'd2:    return 10'd646;
      4'd3:    return 10'd513;
      4'd4:    return 10'd407;
      4'd5:    return 10'd323;
      4'd6:    return 10'd257;
      4'd7:    return 10'd204;
      4'd8:    return 10'd162;
      4'd9:    return 10'd128;
      4'd10:   return 10'd102;
      4'd11:   return 10'd81;
      4'd12:   return 10'd64;
      4'd13:   return 10'd51;
      4'd14:   return 10'd40;
      default: return 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/psg_core.sv
// One SN76489-compatible core: register file, three square-wave tones and an
// LFSR noise channel, presented as four per-channel amplitudes.
module psg_core
  import psg_pkg::*;
#(
  parameter int AMP_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  wr,
  input  logic [7:0]            wr_data,
  output logic [3:0][AMP_W-1:0] amp
);

  logic [2:0]  reg_idx;
  logic [9:0]  period   [3];
  logic [9:0]  tone_cnt [3];
  logic [2:0]  tone_out;
  logic [2:0]  tone_nxt;
  logic [3:0]  att      [4];
  logic [2:0]  noise_ctrl;
  logic [5:0]  noise_cnt;
  logic        noise_tgl;
  logic [14:0] lfsr;
  logic [2:0]  w_idx;
  logic        noise_step;
  logic        lfsr_fb;

  function automatic logic [AMP_W-1:0] vol_scale(input logic [3:0] a);
    logic [AMP_W+9:0] wide;
    wide = {vol_lookup(a), {AMP_W{1'b0}}};
    return wide[AMP_W+9 -: AMP_W];
  endfunction

  // Period 1 pins the output high instead of toggling at the tick rate.
  always_comb begin
    tone_nxt = tone_out;
    for (int ch = 0; ch < 3; ch++) begin
      if (period[ch] == 10'd1)
        tone_nxt[ch] = 1'b1;
      else if (tone_cnt[ch] == '0)
        tone_nxt[ch] = ~tone_out[ch];
    end
  end

  assign w_idx      = wr_data[7] ? wr_data[6:4] : reg_idx;
  assign noise_step = (noise_ctrl[1:0] == 2'b11) ? (~tone_out[2] & tone_nxt[2])
                                                 : (noise_cnt == '0);
  assign lfsr_fb    = noise_ctrl[2] ? (lfsr[0] ^ lfsr[1]) : lfsr[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_idx    <= '0;
      tone_out   <= '0;
      noise_ctrl <= '0;
      noise_cnt  <= '0;
      noise_tgl  <= 1'b0;
      lfsr       <= LFSR_SEED;
      for (int ch = 0; ch < 3; ch++) begin
        period[ch]   <= '0;
        tone_cnt[ch] <= '0;
      end
      for (int ch = 0; ch < 4; ch++) att[ch] <= 4'hF;
    end else begin
      if (tick) begin
        tone_out <= tone_nxt;
        // period 0 wraps to a reload of 1023, i.e. an effective period of 1024
        for (int ch = 0; ch < 3; ch++)
          tone_cnt[ch] <= (tone_cnt[ch] == '0) ? period[ch] - 10'd1 : tone_cnt[ch] - 10'd1;
        if (noise_ctrl[1:0] != 2'b11)
          noise_cnt <= (noise_cnt == '0) ? noise_reload(noise_ctrl[1:0]) : noise_cnt - 6'd1;
        if (noise_step) begin
          noise_tgl <= ~noise_tgl;
          if (!noise_tgl) lfsr <= {lfsr_fb, lfsr[14:1]};
        end
      end
      // Placed after the tick logic so a noise-ctrl write re-seeds over a shift.
      if (wr) begin
        if (wr_data[7]) reg_idx <= wr_data[6:4];
        if (w_idx[0])
          att[w_idx[2:1]] <= wr_data[3:0];
        else if (w_idx == NOISE_CTRL) begin
          noise_ctrl <= wr_data[2:0];
          lfsr       <= LFSR_SEED;
        end else if (wr_data[7])
          period[w_idx[2:1]][3:0] <= wr_data[3:0];
        else
          period[w_idx[2:1]][9:4] <= wr_data[5:0];
      end
    end
  end

  always_comb begin
    amp = '0;
    for (int ch = 0; ch < 3; ch++)
      if (tone_out[ch]) amp[ch] = vol_scale(att[ch]);
    if (lfsr[0]) amp[3] = vol_scale(att[3]);
  end

endmodule

// File: rtl/psg_multi.sv
// NUM_CHIPS sound cores sharing one host write port, with a common tick
// prescaler and a saturating mixer producing one registered sample per tick.
module psg_multi
  import psg_pkg::*;
#(
  parameter int NUM_CHIPS = 2,
  parameter int PRESCALE  = 16,
  parameter int AMP_W     = 10,
  parameter int OUT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 snd_en,
  input  logic [7:0]           data_bus,
  input  logic [NUM_CHIPS-1:0] cs_n,
  input  logic                 we_n,
  output logic [OUT_W-1:0]     sample,
  output logic                 sample_valid
);

  localparam int NCH   = 4 * NUM_CHIPS;
  localparam int SUM_W = AMP_W + $clog2(NCH);
  localparam int SCL_W = SUM_W + OUT_W;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [2:0]                           we_sync;
  logic                                 wr_pulse;
  logic [PRE_W-1:0]                     pre_cnt;
  logic                                 tick;
  logic [NUM_CHIPS-1:0][3:0][AMP_W-1:0] chip_amp;
  logic [SUM_W-1:0]                     mix_sum;
  logic [OUT_W-1:0]                     sample_p1;
  logic                                 vld_p1;

  function automatic logic [OUT_W-1:0] sat_top(input logic [SUM_W-1:0] s);
    logic [SCL_W-1:0] scaled;
    scaled = {s, {OUT_W{1'b0}}} >> SUM_W;
    if (scaled > SCL_W'({OUT_W{1'b1}})) return '1;
    return scaled[OUT_W-1:0];
  endfunction

  // Flops clear to 0 so a we_n low held across reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) we_sync <= '0;
    else       we_sync <= {we_sync[1:0], we_n};
  end

  assign wr_pulse = we_sync[2] & ~we_sync[1];
  assign tick     = snd_en & (pre_cnt == PRE_W'(PRESCALE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pre_cnt <= '0;
    else if (tick)   pre_cnt <= '0;
    else if (snd_en) pre_cnt <= pre_cnt + 1'b1;
  end

  for (genvar i = 0; i < NUM_CHIPS; i++) begin : g_core
    psg_core #(.AMP_W(AMP_W)) u_core (
      .clk     (clk),
      .rst     (reset),
      .tick    (tick),
      .wr      (wr_pulse & ~cs_n[i]),
      .wr_data (data_bus),
      .amp     (chip_amp[i])
    );
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_CHIPS; i++)
      for (int ch = 0; ch < 4; ch++)
        mix_sum = mix_sum + SUM_W'(chip_amp[i][ch]);
  end

  // p0 -> p1: sample the pre-tick mix, visible one clk after the tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= tick;
      if (tick) sample_p1 <= sat_top(mix_sum);
    end
  end

  assign sample       = sample_p1;
  assign sample_valid = vld_p1;

endmodule
